// File: rtl/output_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_pkg
//   Shared definitions for the output port arbiter and its round-robin picker:
//   FSM state encoding, source index constants and the north/south payload
//   width derivation.
// -----------------------------------------------------------------------------
package output_port_arbiter_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Source indices; also the bit positions in empty_in / ren_out.
    localparam logic [1:0] WEST  = 2'd0;
    localparam logic [1:0] EAST  = 2'd1;
    localparam logic [1:0] NORTH = 2'd2;
    localparam logic [1:0] SOUTH = 2'd3;

    localparam int NUM_SRC = 4;

    // Width of a north/south packet: the full packet minus the dx field.
    function automatic int ns_width(input int packet_width,
                                    input int dx_msb,
                                    input int dx_lsb);
        return packet_width - (dx_msb - dx_lsb + 1);
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//   Combinational 4-way round-robin pick. The search starts at last+1 (mod 4)
//   and wraps, so the most recently served source is considered last.
//
//   Ports
//     req   [3:0]  request per source (1 = wants service)
//     last  [1:0]  source granted most recently
//     grant [1:0]  chosen source (equals last when nothing is requested)
//     any          at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter4
    import output_port_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    assign any = |req;

    always_comb begin
        logic [1:0] idx;
        logic       found;
        // NOTE: every variable written here gets a value before any branch, so
        // no path can leave it holding an old value and infer a latch.
        grant = last;
        found = 1'b0;
        idx   = last;
        // Offset 4 wraps to last itself, so it is checked only after the others.
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
//   Arbitrates four source FIFOs (west, east, north, south) onto one registered
//   output port. A grant is held for a burst of up to BURST_MAX packets while
//   the granted FIFO keeps data; then the round-robin pointer moves on.
//   Each packet takes READ (pop the FIFO), CAPTURE (FIFO data is valid, load
//   the output register) and HOLD (wait for the consumer handshake).
//
//   Ports
//     clk                    rising-edge clock
//     rst                    asynchronous, active-low reset
//     empty_in   [3:0]       FIFO empty flags {south, north, east, west}
//     ren_out    [3:0]       FIFO read enables, one-hot, only in READ
//     din_west / din_east    full-width FIFO data
//     din_north / din_south  FIFO data without the dx field (NS_WIDTH bits)
//     dout                   registered output packet
//     dout_src   [1:0]       source index of dout
//     dout_valid             dout holds a packet
//     dout_ready             consumer accepts dout
//     busy                   FSM is not in IDLE
// -----------------------------------------------------------------------------
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter  int PACKET_WIDTH = 30,
    parameter  int DX_MSB       = 29,
    parameter  int DX_LSB       = 21,
    parameter  int BURST_MAX    = 4,
    localparam int NS_WIDTH     = ns_width(PACKET_WIDTH, DX_MSB, DX_LSB)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              empty_in,
    output logic [3:0]              ren_out,
    input  logic [PACKET_WIDTH-1:0] din_west,
    input  logic [PACKET_WIDTH-1:0] din_east,
    input  logic [NS_WIDTH-1:0]     din_north,
    input  logic [NS_WIDTH-1:0]     din_south,
    output logic [PACKET_WIDTH-1:0] dout,
    output logic [1:0]              dout_src,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy
);

    state_t state;
    state_t state_next;

    logic [1:0] grant;       // source owning the current burst
    logic [1:0] last_grant;  // source whose burst ended most recently
    logic [3:0] burst_cnt;   // packets already delivered in this burst

    logic [3:0] req;
    logic [1:0] arb_grant;
    logic       arb_any;

    logic       handshake;
    logic       burst_more;
    logic       start_grant;
    logic       capture;
    logic       hs_continue;
    logic       hs_done;

    logic [PACKET_WIDTH-1:0] din_sel;

    // -------------------------------------------------------------------------
    // Round-robin pick among non-empty sources
    // -------------------------------------------------------------------------
    assign req = ~empty_in;

    rr_arbiter4 u_rr_arbiter4 (
        .req   (req),
        .last  (last_grant),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // -------------------------------------------------------------------------
    // Burst continuation: room for another packet and the same FIFO still has
    // data at the moment of the handshake.
    // -------------------------------------------------------------------------
    assign handshake  = dout_valid && dout_ready;
    assign burst_more = (({1'b0, burst_cnt} + 5'd1) < 5'(BURST_MAX))
                        && !empty_in[grant];

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        ren_out     = 4'b0000;
        start_grant = 1'b0;
        capture     = 1'b0;
        hs_continue = 1'b0;
        hs_done     = 1'b0;

        case (state)
            IDLE: begin
                if (arb_any) begin
                    start_grant = 1'b1;
                    state_next  = READ;
                end
            end

            READ: begin
                ren_out    = 4'b0001 << grant;
                state_next = CAPTURE;
            end

            // FIFO data popped in READ is presented during this cycle.
            CAPTURE: begin
                capture    = 1'b1;
                state_next = HOLD;
            end

            HOLD: begin
                if (handshake) begin
                    if (burst_more) begin
                        hs_continue = 1'b1;
                        state_next  = READ;
                    end else begin
                        hs_done    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Data selection: north/south payloads sit in the low bits, the dx field
    // and anything above NS_WIDTH are zero.
    // -------------------------------------------------------------------------
    always_comb begin
        case (grant)
            WEST:    din_sel = din_west;
            EAST:    din_sel = din_east;
            NORTH:   din_sel = PACKET_WIDTH'(din_north);
            default: din_sel = PACKET_WIDTH'(din_south);
        endcase
    end

    // -------------------------------------------------------------------------
    // Grant, burst counter and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register here is control or a single output word, so
            // all of it is reset; an in-flight packet is simply dropped.
            grant      <= WEST;
            last_grant <= SOUTH;   // west wins the first arbitration
            burst_cnt  <= '0;
            dout       <= '0;
            dout_src   <= WEST;
            dout_valid <= 1'b0;
        end else begin
            if (start_grant) begin
                grant     <= arb_grant;
                burst_cnt <= '0;
            end

            if (hs_continue) begin
                burst_cnt <= burst_cnt + 4'd1;
            end

            if (hs_done) begin
                last_grant <= grant;
            end

            if (capture) begin
                dout       <= din_sel;
                dout_src   <= grant;
                dout_valid <= 1'b1;
            end else if (hs_continue || hs_done) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_port_arbiter
//   Scoreboard bench. Source FIFOs are bench queues; a transaction-level model
//   decides which packet should come out next and when, pushing expectations
//   into a scoreboard that a separate monitor pops on each output handshake.
// -----------------------------------------------------------------------------
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;

    localparam int PW  = 30;
    localparam int DXM = 29;
    localparam int DXL = 21;
    localparam int BM  = 4;
    localparam int NSW = ns_width(PW, DXM, DXL);
    localparam logic [PW-1:0] NS_MASK = {{(PW-NSW){1'b0}}, {NSW{1'b1}}};

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     empty_in;
    logic [3:0]     ren_out;
    logic [PW-1:0]  din_west, din_east;
    logic [NSW-1:0] din_north, din_south;
    logic [PW-1:0]  dout;
    logic [1:0]     dout_src;
    logic           dout_valid;
    logic           dout_ready;
    logic           busy;

    output_port_arbiter #(
        .PACKET_WIDTH (PW),
        .DX_MSB       (DXM),
        .DX_LSB       (DXL),
        .BURST_MAX    (BM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .empty_in   (empty_in),
        .ren_out    (ren_out),
        .din_west   (din_west),
        .din_east   (din_east),
        .din_north  (din_north),
        .din_south  (din_south),
        .dout       (dout),
        .dout_src   (dout_src),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0]    src;
        logic [PW-1:0] data;
    } exp_t;

    exp_t sb[$];

    logic [PW-1:0] q_w[$], q_e[$], q_n[$], q_s[$];

    // Model state: transaction timeline of the packet in flight.
    bit m_active;
    int m_grant, m_last, m_cnt, m_ren_at, m_valid_from;

    // Stimulus knobs.
    int   push_rate  = 0;
    int   ready_mode = 0;   // 0 = always ready, 1 = never ready, 2 = random
    logic rst_req    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int fifo_size(input int i);
        case (i)
            0:       return q_w.size();
            1:       return q_e.size();
            2:       return q_n.size();
            default: return q_s.size();
        endcase
    endfunction

    function automatic logic [PW-1:0] fifo_front(input int i);
        case (i)
            0:       return q_w[0];
            1:       return q_e[0];
            2:       return q_n[0];
            default: return q_s[0];
        endcase
    endfunction

    task automatic fifo_push(input int i, input logic [PW-1:0] d);
        case (i)
            0:       q_w.push_back(d);
            1:       q_e.push_back(d);
            2:       q_n.push_back(d);
            default: q_s.push_back(d);
        endcase
    endtask

    task automatic fifo_pop(input int i, output logic [PW-1:0] d);
        case (i)
            0:       d = q_w.pop_front();
            1:       d = q_e.pop_front();
            2:       d = q_n.pop_front();
            default: d = q_s.pop_front();
        endcase
    endtask

    function automatic bit fifos_empty();
        return (q_w.size() == 0) && (q_e.size() == 0) && (q_n.size() == 0) && (q_s.size() == 0);
    endfunction

    // First requester after `last`, wrapping around four sources.
    function automatic int rr_pick(input int last, input logic [3:0] rq);
        for (int i = 1; i <= 4; i++) begin
            if (rq[(last + i) % 4]) return (last + i) % 4;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = 3;
        m_cnt    = 0;
        sb.delete();
    endtask

    // A packet is decided in cycle k: read in k+1, valid from k+3.
    task automatic start_pkt(input int k);
        exp_t e;
        m_active     = 1'b1;
        m_ren_at     = k + 1;
        m_valid_from = k + 3;
        e.src  = 2'(m_grant);
        e.data = fifo_front(m_grant);
        if (m_grant >= 2) e.data = e.data & NS_MASK;
        sb.push_back(e);
    endtask

    // Advance the model with the inputs the DUT will sample at the next edge.
    task automatic model_step();
        if (!rst) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (empty_in != 4'hF) begin
                m_grant = rr_pick(m_last, ~empty_in);
                m_cnt   = 0;
                start_pkt(cyc);
            end
        end else if (cyc >= m_valid_from && dout_ready) begin
            if ((m_cnt + 1 < BM) && !empty_in[m_grant]) begin
                m_cnt++;
                start_pkt(cyc);
            end else begin
                m_last   = m_grant;
                m_active = 1'b0;
            end
        end
    endtask

    // One clock: check cycle outputs, serve FIFO reads, then drive new inputs.
    task automatic tick();
        logic [PW-1:0] d;
        logic [3:0]    exp_ren;
        @(negedge clk);
        cyc++;
        exp_ren = (m_active && cyc == m_ren_at) ? (4'b0001 << m_grant) : 4'b0000;
        check("ren_out", ren_out, exp_ren);
        check("dout_valid", dout_valid, m_active && cyc >= m_valid_from);
        check("busy", busy, m_active);
        for (int i = 0; i < 4; i++) begin
            if (ren_out[i]) begin
                check("ren_src_nonempty", fifo_size(i) != 0, 1);
                if (fifo_size(i) != 0) begin
                    fifo_pop(i, d);
                    case (i)
                        0:       din_west  = d;
                        1:       din_east  = d;
                        2:       din_north = d[NSW-1:0];
                        default: din_south = d[NSW-1:0];
                    endcase
                end
            end
        end
        #1;
        rst = rst_req;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(99) < push_rate && fifo_size(i) < 8) fifo_push(i, PW'($urandom));
        end
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = 1'b0;
            default: dout_ready = 1'($urandom_range(1));
        endcase
        for (int i = 0; i < 4; i++) empty_in[i] = (fifo_size(i) == 0);
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((m_active || !fifos_empty()) && n < 300) begin
            tick();
            n++;
        end
        check("drained", m_active || !fifos_empty(), 0);
        tick();
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ren_out"}, ren_out, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dout_src"}, dout_src, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: compares each handshaken packet and HOLD stability.
    initial begin
        logic          pv, ph;
        logic [PW-1:0] pd;
        logic [1:0]    ps;
        exp_t          e;
        pv = 1'b0;
        ph = 1'b0;
        pd = '0;
        ps = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                pv = 1'b0;
                continue;
            end
            if (dout_valid && pv && !ph) begin
                check("hold_dout", dout, pd);
                check("hold_src", dout_src, ps);
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_packet at cycle %0d: got src %0d data %0h, expected none", cyc, dout_src, dout);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.data);
                    check("dout_src", dout_src, e.src);
                end
            end
            pv = dout_valid;
            ph = dout_valid && dout_ready;
            pd = dout;
            ps = dout_src;
        end
    end

    initial begin
        bit found;
        rst        = 1'b0;
        empty_in   = 4'hF;
        din_west   = '0;
        din_east   = '0;
        din_north  = '0;
        din_south  = '0;
        dout_ready = 1'b0;
        model_reset();

        run(2);
        check_all_zero("reset");
        rst_req = 1'b1;

        // Single west packet.
        fifo_push(WEST, 30'h1234567);
        run(12);

        // North payload lands zero-extended.
        fifo_push(NORTH, 30'h01FFFFF);
        run(10);

        // Six east packets: burst of BURST_MAX, then a fresh grant.
        for (int i = 0; i < 6; i++) fifo_push(EAST, 30'h100 + PW'(i));
        run(40);

        // Consumer stalls in HOLD, then a single handshake.
        ready_mode = 1;
        fifo_push(SOUTH, 30'h0ABCDE);
        run(16);
        ready_mode = 0;
        run(6);

        // All four sources full at once.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 6; i++) fifo_push(s, PW'($urandom));
        end
        run(100);

        // Random traffic with random backpressure.
        push_rate  = 30;
        ready_mode = 2;
        run(1500);
        push_rate  = 0;
        ready_mode = 0;
        drain();

        // Reset while a packet is in CAPTURE.
        fifo_push(EAST, 30'h2222222);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_active && cyc == m_ren_at + 1) found = 1'b1;
        end
        check("reached_capture", found, 1);
        rst     = 1'b0;
        rst_req = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_reset");
        fifo_push(EAST, 30'h3333333);
        fifo_push(WEST, 30'h0444444);
        run(3);
        rst_req = 1'b1;
        run(20);

        // More random traffic after the abort.
        push_rate  = 20;
        ready_mode = 2;
        run(500);
        push_rate  = 0;
        ready_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
